nes_controller_responder: RTL
=============================

// Module: nes_controller_responder
// PURPOSE
//   Emulates a standard NES controller (4021-style parallel-in/serial-out) on the device side of
//   the NES latch/pulse/data link that Pong drives as the reading end.
//   Snapshots 8 button inputs on latch, then shifts them out active-low, one per pulse rising edge.
//   Used as an on-chip loopback/test controller and as a stand-in controller for bring-up.
//   Link inputs are asynchronous to clk (25.175 MHz) and are synchronized internally.
// PARAMETERS
//   SYNC_STAGES     2     flops per synchronizer on nes_latch, nes_pulse (>=2)
//   TIMEOUT_CYCLES  4096  clk cycles without link activity in SHIFT/DONE before forced return to IDLE
//   IDLE_DATA       1'b1  serial value shifted in behind the 8 buttons (1 = released, as on real pad)
// PORTS
//   clk           in   1  system clock, 25.175 MHz
//   reset_n       in   1  asynchronous active-low reset
//   buttons       in   8  active-high pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   nes_latch     in   1  latch from reader, active high, async
//   nes_pulse     in   1  shift clock from reader, shifts on rising edge, async
//   nes_data      out  1  serial button data, active low (0 = pressed), registered
//   frame_done    out  1  one-clk pulse when the 8th bit has been shifted past
//   busy          out  1  high in LOAD, SHIFT or DONE
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, shreg=8'hFF, bit_cnt=0, timer=0, nes_data=1,
//     frame_done=0, busy=0, all synchronizer flops=0. Reset mid-frame aborts the frame.
//   Sync: latch_s/pulse_s = last stage of SYNC_STAGES chain; buttons double-registered (btn_s).
//     pulse_rise = pulse_s & ~pulse_q; latch_fall = ~latch_s & latch_q (q = 1-cycle delayed copy).
//   nes_data == shreg[0] at all times (registered, no combinational path from pins).
//   Latency: pin transition first sampled at clk edge k -> nes_data updated at edge k+SYNC_STAGES.
//   States:
//     IDLE : shreg holds. pulse_rise ignored. latch_s=1 -> LOAD.
//     LOAD : every cycle shreg <= ~btn_s (nes_data tracks ~A live). pulse_rise ignored.
//            latch_fall -> SHIFT, bit_cnt=0, timer=0; shreg keeps value loaded on last latch-high cycle.
//     SHIFT: pulse_rise -> shreg <= {IDLE_DATA, shreg[7:1]}, bit_cnt++, timer=0.
//            Pulse taking bit_cnt 7->8 -> DONE and frame_done=1 for that one cycle.
//     DONE : pulse_rise -> shreg <= {IDLE_DATA, shreg[7:1]} (output stays IDLE_DATA); no frame_done.
//   latch_s=1 in any state -> LOAD next cycle; latch has priority over a simultaneous pulse_rise.
//   buttons changes outside LOAD never affect the stream in progress (snapshot semantics).
//   Timeout: timer counts clk in SHIFT/DONE, cleared on pulse_rise; at TIMEOUT_CYCLES-1 ->
//     IDLE, shreg <= {8{IDLE_DATA}}, bit_cnt=0. timer saturates, never wraps. Not active in LOAD.
//   bit_cnt is 4 bits, saturates at 8. Widths: timer = $clog2(TIMEOUT_CYCLES) bits.
//   Pulses arriving < SYNC_STAGES+1 clk apart are not guaranteed to be resolved (reader runs us-scale).
// TESTING
//   1 reset_n=0 with nes_pulse toggling -> nes_data=1, frame_done=0, busy=0 throughout.
//   2 buttons=8'h05, latch 12us, 8 pulses @6us -> nes_data after latch,then each pulse: 0,1,0,1,1,1,1,1,
//     then 1; frame_done exactly once, SYNC_STAGES clk after 8th pulse first sampled.
//   3 buttons=8'h80, latch, 3 pulses, latch again, 8 pulses -> stream restarts: 1,1,1,1,1,1,1,0 then 1.
//   4 buttons=8'h01 latched, change to 8'hFE after latch fall, 8 pulses -> 0,1,1,1,1,1,1,1 (snapshot).
//   5 latch, 2 pulses, idle 4096 clk -> busy=0, nes_data=1; next pulse without latch ignored.
//   6 nes_pulse rising while nes_latch=1 with buttons=8'h01 -> nes_data stays 0, bit_cnt stays 0.

Source files
------------

// File: rtl/nes_controller_responder_if.sv
// nes_controller_responder_if: NES latch/pulse/data link between reader (master) and pad (slave).
interface nes_controller_responder_if;
  logic nes_latch;
  logic nes_pulse;
  logic nes_data;
  modport master (output nes_latch, output nes_pulse, input nes_data);
  modport slave (input nes_latch, input nes_pulse, output nes_data);
endinterface

// File: rtl/nes_controller_responder.sv
// nes_controller_responder: 4021-style NES pad emulation; snapshots buttons on latch, shifts them out active-low.
module nes_controller_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic IDLE_DATA = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [7:0] buttons,
  output logic frame_done,
  output logic busy,
  nes_controller_responder_if.slave link
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] latch_sync_q, pulse_sync_q;
  logic latch_q, pulse_q;
  logic [7:0] btn_m_q, btn_s_q, shreg_q;
  logic [3:0] bit_cnt_q;
  logic [TW-1:0] timer_q;
  logic frame_done_q, busy_q;
  logic latch_s, pulse_s, pulse_rise, latch_fall;
  assign latch_s = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s = pulse_sync_q[SYNC_STAGES-1];
  assign pulse_rise = pulse_s & ~pulse_q;
  assign latch_fall = ~latch_s & latch_q;
  assign link.nes_data = shreg_q[0];
  assign frame_done = frame_done_q;
  assign busy = busy_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
      btn_m_q <= '0;
      btn_s_q <= '0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], link.nes_latch};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], link.nes_pulse};
      latch_q <= latch_s;
      pulse_q <= pulse_s;
      btn_m_q <= buttons;
      btn_s_q <= btn_m_q;
    end
  // Latch wins over everything, including a pulse edge in the same cycle.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= 8'hFF;
      bit_cnt_q <= '0;
      timer_q <= '0;
      frame_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (latch_s) begin
        state_q <= LOAD;
        busy_q <= 1'b1;
        shreg_q <= ~btn_s_q;
        bit_cnt_q <= '0;
        timer_q <= '0;
      end else begin
        case (state_q)
          LOAD: if (latch_fall) begin
            state_q <= SHIFT;
            bit_cnt_q <= '0;
            timer_q <= '0;
          end
          SHIFT, DONE: if (pulse_rise) begin
            shreg_q <= {IDLE_DATA, shreg_q[7:1]};
            timer_q <= '0;
            if (state_q == SHIFT) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                state_q <= DONE;
                frame_done_q <= 1'b1;
              end
            end
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            shreg_q <= {8{IDLE_DATA}};
            bit_cnt_q <= '0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
endmodule
